// File: rtl/mcu_bus_master.sv
// Single-outstanding command master for a simple MCU chip-enable bus.
// Each access waits for a level ack or a timeout, then leaves a fixed idle gap on the bus.
module mcu_bus_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_ce,
  output logic        bus_oe,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dato,
  input  logic        bus_ack,
  input  logic [31:0] bus_dati
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] GapLast     = 16'(GAP_CYC - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StGap} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic        latch_cmd;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_cmd   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_we && (cmd_be == 4'h0)) begin
            // Nothing to strobe: answer immediately without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
          end else begin
            latch_cmd = 1'b1;
            state_d   = StAccess;
            cnt_d     = 16'h0;
          end
        end
      end
      StAccess: begin
        if (bus_ack) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : bus_dati;
          state_d     = StGap;
          cnt_d       = 16'h0;
        end else if (cnt_q == TimeoutLast) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
          state_d     = StGap;
          cnt_d       = 16'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = 16'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 16'h0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (latch_cmd) begin
        we_q    <= cmd_we;
        be_q    <= cmd_be;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
    end
  end

  // Strobes decode straight from state so reset drops them without waiting for a clock.
  assign cmd_ready = (state_q == StIdle);
  assign bus_ce    = (state_q == StAccess);
  assign bus_oe    = bus_ce && !we_q;
  assign bus_we    = (bus_ce && we_q) ? be_q : 4'h0;
  assign bus_addr  = addr_q;
  assign bus_dato  = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mcu_bus_master.sv
// Randomized bench for mcu_bus_master against a per-command timing/response model,
// with a responder that acks after a programmable number of ce cycles.
module tb_mcu_bus_master;

  localparam int unsigned TO  = 8;
  localparam int unsigned GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_ce;
  logic        bus_oe;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_dato;
  logic        bus_ack;
  logic [31:0] bus_dati;

  int unsigned ack_delay = 0;
  logic [31:0] resp_data = '0;
  logic        stray = 1'b0;
  int unsigned ce_seen = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcu_bus_master #(.TIMEOUT(TO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_ce(bus_ce), .bus_oe(bus_oe), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_dato(bus_dato), .bus_ack(bus_ack), .bus_dati(bus_dati)
  );

  // Responder: ack rises once ce has been high for ack_delay cycles, held while ce high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !bus_ce) ce_seen <= 0;
    else                   ce_seen <= ce_seen + 1;
  end
  assign bus_ack  = stray || (bus_ce && (ce_seen >= ack_delay));
  assign bus_dati = bus_ack ? resp_data : 32'hBAD0_BAD0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int unsigned d, input logic [31:0] dati);
    bit          bypass, exp_err, seen, bad_bus;
    int unsigned exp_ce, exp_lat, ce_cnt, n, waited;
    logic [31:0] exp_rd;
    bypass  = we && (be == 4'h0);
    exp_err = !bypass && (d >= TO);
    exp_ce  = bypass ? 0 : ((d + 1 < TO) ? d + 1 : TO);
    exp_lat = exp_ce + 1;
    exp_rd  = (bypass || we || exp_err) ? 32'h0 : dati;
    ack_delay = d;
    resp_data = dati;
    seen = 0; bad_bus = 0; ce_cnt = 0; waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = $urandom_range(0, 1); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_be = 4'($urandom);
    n = 1;
    while (n <= TO + 4) begin
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      if (bus_ce) begin
        ce_cnt++;
        if (bus_oe !== !we || bus_we !== (we ? be : 4'h0) || bus_addr !== addr ||
            bus_dato !== wdata) bad_bus = 1;
      end
      @(negedge clk);
      n++;
    end
    check_eq("rsp_seen", 32'(seen), 32'd1);
    check_eq("rsp_latency", 32'(n), 32'(exp_lat));
    check_eq("ce_cycles", 32'(ce_cnt), 32'(exp_ce));
    check_eq("bus_lines", 32'(bad_bus), 32'd0);
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("ce_at_rsp", 32'(bus_ce), 32'd0);
    check_eq("ready_at_rsp", 32'(cmd_ready), 32'(bypass));
    if (!bypass) begin
      stray = 1'($urandom_range(0, 1));
      for (int g = 1; g < int'(GAP); g++) begin
        @(negedge clk);
        check_eq("gap_valid", 32'(rsp_valid), 32'd0);
        check_eq("gap_ce", 32'(bus_ce), 32'd0);
        check_eq("gap_ready", 32'(cmd_ready), 32'd0);
      end
      @(negedge clk);
      stray = 1'b0;
    end else begin
      @(negedge clk);
    end
    check_eq("post_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_valid", 32'(rsp_valid), 32'd0);
    check_eq("hold_err", 32'(rsp_err), 32'(exp_err));
    check_eq("hold_rdata", rsp_rdata, exp_rd);
  endtask

  initial begin
    int unsigned r, d;
    logic [3:0]  be;
    #3;
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_ce_oe_we", {26'h0, bus_ce, bus_oe, bus_we}, 32'h0);
    check_eq("rst_addr", bus_addr, 32'h0);
    check_eq("rst_dato", bus_dato, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 6, 32'hDEADBEEF);
    do_cmd(1'b1, 32'h20, 32'h12345678, 4'h3, 2, 32'h55AA55AA);
    do_cmd(1'b0, 32'h30, 32'h0, 4'h0, 40, 32'h11112222);
    do_cmd(1'b0, 32'h40, 32'h0, 4'h0, TO - 1, 32'hCAFEF00D);
    do_cmd(1'b1, 32'h50, 32'hA5A5A5A5, 4'h0, 0, 32'h0);
    do_cmd(1'b1, 32'h60, 32'h0F0F0F0F, 4'hC, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 11);
      d  = (r > 9) ? 20 : r;
      be = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, be, d, $urandom);
    end

    // Reset in the middle of a read that would otherwise time out.
    ack_delay = 100;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h70; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_ce", 32'(bus_ce), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ce", 32'(bus_ce), 32'd0);
    check_eq("arst_ready", 32'(cmd_ready), 32'd1);
    check_eq("arst_valid", 32'(rsp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("in_rst_valid", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < TO + 2; k++) begin
      @(negedge clk);
      check_eq("after_rst_valid", 32'(rsp_valid), 32'd0);
    end
    do_cmd(1'b0, 32'h80, 32'h0, 4'h0, 3, 32'h87654321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
